// File: rtl/jtag_host_if.sv
// Command/response bus of the JTAG host.
//   i_cmdValid/o_cmdReady : command handshake
//   i_cmdType/i_cmdLen/i_cmdData : command payload (type, bit/cycle count, TDI bits)
//   o_rspValid/o_rspData  : one-cycle completion pulse and captured TDO bits
// slave  : seen by the host (jtag_host)
// master : seen by the command issuer
interface jtag_host_if;
  logic        i_cmdValid;
  logic        o_cmdReady;
  logic [1:0]  i_cmdType;
  logic [5:0]  i_cmdLen;
  logic [31:0] i_cmdData;
  logic        o_rspValid;
  logic [31:0] o_rspData;

  modport slave (
    input  i_cmdValid, i_cmdType, i_cmdLen, i_cmdData,
    output o_cmdReady, o_rspValid, o_rspData
  );

  modport master (
    output i_cmdValid, i_cmdType, i_cmdLen, i_cmdData,
    input  o_cmdReady, o_rspValid, o_rspData
  );
endinterface

// File: rtl/jtag_host.sv
// JTAG host: turns TAP-reset / shift-IR / shift-DR / run-idle commands into
// TCK/TMS/TDI sequences and captures TDO during shift periods.
//   i_clk, i_rstn          : system clock, asynchronous active-low reset
//   bus (jtag_host_if.slave): command handshake and completion response
//   o_jtagTCK/TMS/TDI      : JTAG pins to the target
//   i_jtagTDO              : JTAG data from the target
// CLK_DIV: i_clk cycles per TCK half-period (1..255).
module jtag_host #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  jtag_host_if.slave bus,
  output logic       o_jtagTCK,
  output logic       o_jtagTMS,
  output logic       o_jtagTDI,
  input  logic       i_jtagTDO
);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_SHIFT, S_TAIL} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d, next_st;
  logic [5:0]  cnt_q, cnt_d, next_cnt, last_idx, len_in;
  logic [7:0]  div_q, div_d;
  logic        tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic [1:0]  type_q, type_d, drv;
  logic [5:0]  len_q, len_d;
  logic [31:0] data_q, data_d, cap_q, cap_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  // Number of HEAD periods; TAP reset and run-idle finish in HEAD.
  function automatic logic [5:0] head_len(input logic [1:0] typ, input logic [5:0] len);
    case (typ)
      2'b00:   return 6'd6;
      2'b01:   return 6'd4;
      2'b10:   return 6'd3;
      default: return len;
    endcase
  endfunction

  // {TMS, TDI} for TCK period cnt of state st.
  function automatic logic [1:0] drive(input state_t st, input logic [5:0] cnt,
                                       input logic [1:0] typ, input logic [5:0] len,
                                       input logic [31:0] data);
    logic tms, tdi;
    tms = 1'b0;
    tdi = 1'b0;
    case (st)
      S_HEAD: begin
        case (typ)
          2'b00:   tms = (cnt < 6'd5);
          2'b01:   tms = (cnt < 6'd2);
          2'b10:   tms = (cnt == 6'd0);
          default: tms = 1'b0;
        endcase
      end
      S_SHIFT: begin
        tms = (cnt == len - 6'd1);
        tdi = data[cnt[4:0]];
      end
      S_TAIL:  tms = (cnt == 6'd0);
      default: ;
    endcase
    return {tms, tdi};
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    type_d      = type_q;
    len_d       = len_q;
    data_d      = data_q;
    cap_d       = cap_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    next_st     = state_q;
    next_cnt    = cnt_q;
    last_idx    = '0;
    drv         = '0;

    if (bus.i_cmdLen == 6'd0)      len_in = 6'd1;
    else if (bus.i_cmdLen > 6'd32) len_in = 6'd32;
    else                           len_in = bus.i_cmdLen;

    if (state_q == S_IDLE) begin
      if (bus.i_cmdValid) begin
        state_d = S_HEAD;
        cnt_d   = '0;
        div_d   = '0;
        tck_d   = 1'b0;
        type_d  = bus.i_cmdType;
        len_d   = len_in;
        data_d  = bus.i_cmdData;
        cap_d   = '0;
        drv     = drive(S_HEAD, 6'd0, bus.i_cmdType, len_in, bus.i_cmdData);
        tms_d   = drv[1];
        tdi_d   = drv[0];
      end
    end else if (div_q != DIV_LAST) begin
      div_d = div_q + 8'd1;
    end else begin
      div_d = '0;
      tck_d = ~tck_q;
      if (!tck_q) begin
        // Rising TCK: sample TDO on this edge.
        if (state_q == S_SHIFT) cap_d[cnt_q[4:0]] = i_jtagTDO;
      end else begin
        // Falling TCK: end of period, set up the next one.
        case (state_q)
          S_HEAD:  last_idx = head_len(type_q, len_q) - 6'd1;
          S_SHIFT: last_idx = len_q - 6'd1;
          default: last_idx = 6'd1;
        endcase
        if (cnt_q != last_idx) begin
          next_cnt = cnt_q + 6'd1;
        end else begin
          next_cnt = '0;
          case (state_q)
            S_HEAD:  next_st = (type_q == 2'b00 || type_q == 2'b11) ? S_IDLE : S_SHIFT;
            S_SHIFT: next_st = S_TAIL;
            default: next_st = S_IDLE;
          endcase
        end
        state_d = next_st;
        cnt_d   = next_cnt;
        if (next_st == S_IDLE) begin
          tms_d       = 1'b0;
          tdi_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = (type_q[1] ^ type_q[0]) ? cap_q : '0;
        end else begin
          drv   = drive(next_st, next_cnt, type_q, len_q, data_q);
          tms_d = drv[1];
          tdi_d = drv[0];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      type_q      <= '0;
      len_q       <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      type_q      <= type_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.o_cmdReady = (state_q == S_IDLE);
  assign bus.o_rspValid = rsp_valid_q;
  assign bus.o_rspData  = rsp_data_q;
  assign o_jtagTCK      = tck_q;
  assign o_jtagTMS      = tms_q;
  assign o_jtagTDI      = tdi_q;

endmodule

// File: tb/tb_jtag_host.sv
// Directed bench for jtag_host: one instance with CLK_DIV=2 (TAP reset) and
// one with CLK_DIV=4 (shifts, run-idle, length limits, abort, busy/back-to-back).
module tb_jtag_host;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  jtag_host_if if2();
  jtag_host_if if4();
  logic tck2, tms2, tdi2, tck4, tms4, tdi4;
  logic tdo4_one = 1'b0;
  logic tgt4 = 1'b0;
  logic tdo4;

  // Target side of the loopback: one TCK-clocked stage from TDI to TDO.
  always @(posedge tck4) tgt4 <= tdi4;
  assign tdo4 = tdo4_one ? 1'b1 : tgt4;

  jtag_host #(.CLK_DIV(2)) u_dut2 (
    .i_clk(clk), .i_rstn(rst_n), .bus(if2),
    .o_jtagTCK(tck2), .o_jtagTMS(tms2), .o_jtagTDI(tdi2), .i_jtagTDO(1'b1)
  );

  jtag_host #(.CLK_DIV(4)) u_dut4 (
    .i_clk(clk), .i_rstn(rst_n), .bus(if4),
    .o_jtagTCK(tck4), .o_jtagTMS(tms4), .o_jtagTDI(tdi4), .i_jtagTDO(tdo4)
  );

  // Monitor: logs TMS/TDI at every TCK rise and counts response pulses.
  int n2 = 0, n4 = 0, rc2 = 0, rc4 = 0;
  int unsigned rcyc2 = 0, rcyc4 = 0, rise4_first = 0;
  logic [63:0] tmsl2 = '0, tdil2 = '0, tmsl4 = '0, tdil4 = '0;
  logic p2 = 1'b0, p4 = 1'b0;
  int clr_seq = 0;
  int clr_seen = 0;

  always @(posedge clk) begin
    #1;
    if (clr_seq != clr_seen) begin
      n2 = 0; n4 = 0; rc2 = 0; rc4 = 0;
      tmsl2 = '0; tdil2 = '0; tmsl4 = '0; tdil4 = '0;
      clr_seen = clr_seq;
    end
    if (tck4 && !p4) begin
      if (n4 == 0) rise4_first = cyc;
      if (n4 < 64) begin tmsl4[n4] = tms4; tdil4[n4] = tdi4; end
      n4++;
    end
    if (tck2 && !p2) begin
      if (n2 < 64) begin tmsl2[n2] = tms2; tdil2[n2] = tdi2; end
      n2++;
    end
    p4 = tck4;
    p2 = tck2;
    if (if4.o_rspValid) begin rc4++; rcyc4 = cyc; end
    if (if2.o_rspValid) begin rc2++; rcyc2 = cyc; end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send4(input logic [1:0] t, input logic [5:0] l, input logic [31:0] d,
                       output int unsigned t0);
    int k;
    k = 0;
    @(negedge clk);
    while (!if4.o_cmdReady && k < 1000) begin @(negedge clk); k++; end
    chk("ready4_wait", (k < 1000), 1);
    clr_seq++;
    if4.i_cmdType  = t;
    if4.i_cmdLen   = l;
    if4.i_cmdData  = d;
    if4.i_cmdValid = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    if4.i_cmdValid = 1'b0;
  endtask

  task automatic wait4(input int budget);
    int k;
    k = 0;
    while (rc4 == 0 && k < budget) begin @(negedge clk); k++; end
    chk("rsp4_timeout", (rc4 != 0), 1);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0, r1;
    int k;
    if2.i_cmdValid = 1'b0; if2.i_cmdType = '0; if2.i_cmdLen = '0; if2.i_cmdData = '0;
    if4.i_cmdValid = 1'b0; if4.i_cmdType = '0; if4.i_cmdLen = '0; if4.i_cmdData = '0;

    // Reset values while held, and after release with no command.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs4", {if4.o_cmdReady, if4.o_rspValid, tck4, tms4, tdi4}, 5'b10010);
    chk("rst_data4", if4.o_rspData, 0);
    chk("rst_outs2", {if2.o_cmdReady, if2.o_rspValid, tck2, tms2, tdi2}, 5'b10010);
    rst_n = 1'b1;
    clr_seq++;
    repeat (10) @(negedge clk);
    chk("idle_outs4", {if4.o_cmdReady, if4.o_rspValid, tck4, tms4, tdi4}, 5'b10010);
    chk("idle_tck4", n4, 0);
    chk("idle_outs2", {if2.o_cmdReady, if2.o_rspValid, tck2, tms2, tdi2}, 5'b10010);

    // TAP reset on the CLK_DIV=2 instance.
    clr_seq++;
    if2.i_cmdType = 2'b00; if2.i_cmdLen = 6'd6; if2.i_cmdData = 32'hFFFF_FFFF;
    if2.i_cmdValid = 1'b1;
    @(posedge clk); #1; t0 = cyc;
    if2.i_cmdValid = 1'b0;
    k = 0;
    while (rc2 == 0 && k < 200) begin @(negedge clk); k++; end
    chk("rsp2_timeout", (rc2 != 0), 1);
    repeat (6) @(negedge clk);
    chk("tap_periods", n2, 6);
    chk("tap_tms", tmsl2[5:0], 6'h1F);
    chk("tap_tdi", tdil2[5:0], 0);
    chk("tap_lat", rcyc2 - t0, 24);
    chk("tap_data", if2.o_rspData, 0);
    chk("tap_pulses", rc2, 1);

    // Shift DR, 8 bits, loopback through one target stage.
    tdo4_one = 1'b0;
    send4(2'b10, 6'd8, 32'h1234_56A5, t0);
    wait4(400);
    chk("dr8_periods", n4, 13);
    chk("dr8_tms", tmsl4[12:0], 13'h0C01);
    chk("dr8_tdi_shift", tdil4[10:3], 8'hA5);
    chk("dr8_tdi_hdr_tail", {tdil4[12:11], tdil4[2:0]}, 0);
    chk("dr8_first_rise", rise4_first - t0, 4);
    chk("dr8_lat", rcyc4 - t0, 104);
    chk("dr8_data", if4.o_rspData, 32'h0000_004A);
    chk("dr8_pulses", rc4, 1);
    repeat (20) @(negedge clk);
    chk("gap_pins", {tck4, tms4, tdi4}, 0);
    chk("gap_hold", if4.o_rspData, 32'h0000_004A);

    // Shift IR, 32 bits, TDO tied high.
    tdo4_one = 1'b1;
    send4(2'b01, 6'd32, 32'hDEAD_BEEF, t0);
    wait4(800);
    chk("ir32_periods", n4, 38);
    chk("ir32_tms", tmsl4[37:0], 38'h18_0000_0003);
    chk("ir32_tdi_shift", tdil4[35:4], 32'hDEAD_BEEF);
    chk("ir32_tdi_hdr_tail", {tdil4[37:36], tdil4[3:0]}, 0);
    chk("ir32_lat", rcyc4 - t0, 304);
    chk("ir32_data", if4.o_rspData, 32'hFFFF_FFFF);

    // Run-idle with length 0 behaves as length 1; response data cleared.
    send4(2'b11, 6'd0, 32'hFFFF_FFFF, t0);
    wait4(100);
    chk("idle0_periods", n4, 1);
    chk("idle0_pins", {tmsl4[0], tdil4[0]}, 0);
    chk("idle0_lat", rcyc4 - t0, 8);
    chk("idle0_data", if4.o_rspData, 0);

    // Shift DR with length 40 behaves as length 32.
    send4(2'b10, 6'd40, 32'h0, t0);
    wait4(800);
    chk("dr40_periods", n4, 37);
    chk("dr40_tms", tmsl4[36:0], 37'h0C_0000_0001);
    chk("dr40_tdi", tdil4[36:0], 0);
    chk("dr40_lat", rcyc4 - t0, 296);
    chk("dr40_data", if4.o_rspData, 32'hFFFF_FFFF);

    // Reset in the middle of shift bit 3 aborts with no response.
    send4(2'b10, 6'd8, 32'h0000_00FF, t0);
    k = 0;
    while (n4 < 7 && k < 200) begin @(negedge clk); k++; end
    chk("abort_reach", (n4 >= 7), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {if4.o_cmdReady, if4.o_rspValid, tck4, tms4, tdi4}, 5'b10010);
    chk("abort_data", if4.o_rspData, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    chk("abort_no_rsp", rc4, 0);

    // Valid held high: one command per ready window, next accepted right after completion.
    @(negedge clk);
    clr_seq++;
    if4.i_cmdType = 2'b11; if4.i_cmdLen = 6'd2; if4.i_cmdData = '0;
    if4.i_cmdValid = 1'b1;
    @(posedge clk); #1; t0 = cyc;
    k = 0;
    while (rc4 == 0 && k < 200) begin @(negedge clk); k++; end
    chk("busy_timeout", (rc4 != 0), 1);
    r1 = rcyc4;
    chk("busy_periods", n4, 2);
    chk("busy_pulses", rc4, 1);
    chk("busy_lat", r1 - t0, 16);
    @(posedge clk); #1;
    chk("b2b_accept", if4.o_cmdReady, 0);
    if4.i_cmdValid = 1'b0;
    k = 0;
    while (rc4 < 2 && k < 200) begin @(negedge clk); k++; end
    repeat (6) @(negedge clk);
    chk("b2b_pulses", rc4, 2);
    chk("b2b_periods", n4, 4);
    chk("b2b_lat", rcyc4 - r1, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
